// File: rtl/rr_priority_arbiter.sv
// Registered request arbiter: fixed-priority or round-robin selection with
// grant lock and a bounded hold time when other requesters are waiting.
module rr_priority_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 mode_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic                 valid_o
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [7:0]           hold_q, hold_d;

  logic                 owner_req;
  logic                 others_pending;
  logic                 keep_grant;
  logic [NUM_PORTS-1:0] cand;
  logic                 found;
  logic [IDX_W-1:0]     win;
  int                   pos;

  // grant_q is one-hot or zero, so masking it isolates the owner's request.
  assign owner_req      = |(grant_q & req_i);
  assign others_pending = |(req_i & ~grant_q);
  assign keep_grant     = owner_req && ((hold_q < HOLD_LIM) || !others_pending);

  // Leaving the hold case with the owner still requesting can only mean
  // preemption, so its bit is dropped from the candidates.
  always_comb begin
    cand  = owner_req ? (req_i & ~grant_q) : req_i;
    found = 1'b0;
    win   = '0;
    pos   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pos = mode_i ? ((int'(ptr_q) + i) % NUM_PORTS) : i;
      if (!found && cand[pos]) begin
        found = 1'b1;
        win   = IDX_W'(pos);
      end
    end
  end

  always_comb begin
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (keep_grant) begin
      if (hold_q < HOLD_LIM) hold_d = hold_q + 8'd1;
    end else if (found) begin
      grant_d = NUM_PORTS'(1) << win;
      idx_d   = win;
      valid_d = 1'b1;
      hold_d  = '0;
      ptr_d   = (int'(win) == NUM_PORTS - 1) ? '0 : win + IDX_W'(1);
    end else begin
      grant_d = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Bench for rr_priority_arbiter: directed scenarios plus random traffic,
// all compared against an integer-level model of owner, tenure and pointer.
module tb_rr_priority_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req_i;
  logic         mode_i;
  logic [N-1:0] grant_o;
  logic [1:0]   grant_idx_o;
  logic         valid_o;

  int checks   = 0;
  int failures = 0;

  // Reference state: who owns the resource, how many extra cycles it has
  // kept it, and where the round-robin search starts next.
  int m_own;
  int m_cnt;
  int m_ptr;

  rr_priority_arbiter #(.NUM_PORTS(N), .MAX_HOLD(MH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req_i),
    .mode_i      (mode_i),
    .grant_o     (grant_o),
    .grant_idx_o (grant_idx_o),
    .valid_o     (valid_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_own = -1;
    m_cnt = 0;
    m_ptr = 0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] req, input logic md);
    bit others;
    int excl;
    int w;
    int p;
    others = 1'b0;
    for (int n = 0; n < N; n++)
      if (n != m_own && req[n]) others = 1'b1;
    if (m_own >= 0 && req[m_own] && (m_cnt < MH - 1 || !others)) begin
      if (m_cnt < MH - 1) m_cnt++;
      return;
    end
    excl = (m_own >= 0 && req[m_own]) ? m_own : -1;
    w = -1;
    for (int k = 0; k < N; k++) begin
      p = md ? (m_ptr + k) % N : k;
      if (w < 0 && p != excl && req[p]) w = p;
    end
    if (w >= 0) begin
      m_own = w;
      m_ptr = (w + 1) % N;
    end else begin
      m_own = -1;
    end
    m_cnt = 0;
  endfunction

  task automatic cmp_model(input string tag);
    logic [N-1:0] eg;
    eg = (m_own >= 0) ? (N'(1) << m_own) : '0;
    chk({tag, ".grant"}, 32'(grant_o), 32'(eg));
    chk({tag, ".idx"}, 32'(grant_idx_o), (m_own >= 0) ? m_own : 0);
    chk({tag, ".valid"}, 32'(valid_o), 32'(m_own >= 0));
  endtask

  // Called 1 time unit after a rising edge; drives, clocks, then compares.
  task automatic step(input string tag, input logic [N-1:0] req, input logic md);
    req_i  = req;
    mode_i = md;
    @(posedge clk);
    model_edge(req, md);
    #1;
    cmp_model(tag);
    $display("txn %s req=%b mode=%0d grant=%b idx=%0d", tag, req, md, grant_o, grant_idx_o);
  endtask

  // Pulse reset between edges and verify the outputs clear without a clock.
  task automatic mid_reset(input string tag);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_grant"}, 32'(grant_o), 32'd0);
    chk({tag, ".rst_valid"}, 32'(valid_o), 32'd0);
    chk({tag, ".rst_idx"}, 32'(grant_idx_o), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    req_i  = 4'b1111;
    mode_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.grant", 32'(grant_o), 32'd0);
    chk("reset.valid", 32'(valid_o), 32'd0);
    rst_n = 1'b1;
    step("rst_release", 4'b1111, 1'b1);
    chk("rst_release.first", 32'(grant_o), 32'b0001);

    // Round-robin fairness with everyone requesting.
    for (int c = 0; c < 32; c++) step("rr_fair", 4'b1111, 1'b1);

    // Latency and release.
    mid_reset("lat");
    for (int c = 0; c < 3; c++) begin
      step("lat", 4'b0100, 1'b1);
      chk("lat.idx2", 32'(grant_idx_o), 32'd2);
    end
    step("lat_drop", 4'b0000, 1'b1);
    chk("lat_drop.zero", 32'(grant_o), 32'd0);

    // Fixed priority with preemption, then an uncontended owner.
    for (int c = 0; c < 16; c++) step("fixed_pre", 4'b0011, 1'b0);
    for (int c = 0; c < 12; c++) begin
      step("fixed_solo", 4'b0001, 1'b0);
      chk("fixed_solo.p0", 32'(grant_o), 32'b0001);
    end

    // Zero-bubble handoff from port 1 to port 3.
    step("bubble_a", 4'b0010, 1'b1);
    chk("bubble_a.p1", 32'(grant_o), 32'b0010);
    step("bubble_b", 4'b1000, 1'b1);
    chk("bubble_b.p3", 32'(grant_o), 32'b1000);

    // Asynchronous reset while port 2 holds; search restarts from port 0.
    step("async_hold", 4'b0100, 1'b1);
    step("async_hold", 4'b0100, 1'b1);
    mid_reset("async");
    step("async_after", 4'b1100, 1'b1);
    chk("async_after.p2", 32'(grant_o), 32'b0100);

    // Random traffic with occasional mode flips and resets.
    begin
      logic md;
      logic [N-1:0] r;
      md = 1'b1;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 49) == 0) md = ~md;
        if ($urandom_range(0, 3) == 0) r = N'($urandom);
        else r = req_i | N'($urandom_range(0, 15) & $urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) r = r & ~grant_o;
        if ($urandom_range(0, 499) == 0) mid_reset("rand");
        step("rand", r, md);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
